// File: rtl/simm_arbiter.sv
// Shares the SIMM controller between CPU and DMA; CPU priority, DMA forced in after STARVE_LIMIT lost rounds.
// Grant one edge after cs is sampled; mem_* pass through combinationally; losing requester held in wait.
module simm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_cs,
    input  logic       cpu_ds,
    input  logic       cpu_rn_w,
    input  logic       cpu_bank_addr,
    input  logic [3:0] cpu_byte_selects,
    input  logic       dma_cs,
    input  logic       dma_ds,
    input  logic       dma_rn_w,
    input  logic       dma_bank_addr,
    input  logic [3:0] dma_byte_selects,
    input  logic       mem_waitstate,
    output logic       mem_cs,
    output logic       mem_ds,
    output logic       mem_rn_w,
    output logic       mem_bank_addr,
    output logic [3:0] mem_byte_selects,
    output logic       grant_dma,
    output logic       cpu_waitstate,
    output logic       dma_waitstate
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        DMA_OWN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic [3:0] starve_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            starve_count <= 4'd0;
            grant_dma    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_cs && dma_cs) begin
                        if (starve_count == LIMIT) begin
                            state        <= DMA_OWN;
                            grant_dma    <= 1'b1;
                            starve_count <= 4'd0;
                        end else begin
                            state        <= CPU_OWN;
                            starve_count <= starve_count + 4'd1;
                        end
                    end else if (cpu_cs) begin
                        state        <= CPU_OWN;
                        starve_count <= 4'd0;
                    end else if (dma_cs) begin
                        state        <= DMA_OWN;
                        grant_dma    <= 1'b1;
                        starve_count <= 4'd0;
                    end else begin
                        starve_count <= 4'd0;
                    end
                end
                CPU_OWN: begin
                    if (!cpu_cs) state <= RELEASE;
                end
                DMA_OWN: begin
                    if (!dma_cs) begin
                        state     <= RELEASE;
                        grant_dma <= 1'b0;
                    end
                end
                RELEASE: state <= IDLE;
                default: begin
                    state     <= IDLE;
                    grant_dma <= 1'b0;
                end
            endcase
        end
    end

    // Owner's qualifiers reach the controller unregistered so completion adds no latency.
    always_comb begin
        mem_cs           = 1'b0;
        mem_ds           = 1'b0;
        mem_rn_w         = 1'b1;
        mem_bank_addr    = 1'b0;
        mem_byte_selects = 4'b0000;
        case (state)
            CPU_OWN: begin
                mem_cs           = cpu_cs;
                mem_ds           = cpu_ds;
                mem_rn_w         = cpu_rn_w;
                mem_bank_addr    = cpu_bank_addr;
                mem_byte_selects = cpu_byte_selects;
            end
            DMA_OWN: begin
                mem_cs           = dma_cs;
                mem_ds           = dma_ds;
                mem_rn_w         = dma_rn_w;
                mem_bank_addr    = dma_bank_addr;
                mem_byte_selects = dma_byte_selects;
            end
            default: ;
        endcase
    end

    assign cpu_waitstate = (state == CPU_OWN) ? mem_waitstate : cpu_cs;
    assign dma_waitstate = (state == DMA_OWN) ? mem_waitstate : dma_cs;

endmodule

// File: tb/tb_simm_arbiter.sv
// Directed bench for simm_arbiter: reset, single-owner cycles, starvation rotation, abort, async reset.
module tb_simm_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_cs = 1'b0, cpu_ds = 1'b0, cpu_rn_w = 1'b1, cpu_bank_addr = 1'b0;
    logic [3:0] cpu_byte_selects = 4'b0000;
    logic       dma_cs = 1'b0, dma_ds = 1'b0, dma_rn_w = 1'b1, dma_bank_addr = 1'b0;
    logic [3:0] dma_byte_selects = 4'b0000;
    logic       mem_waitstate = 1'b1;
    logic       mem_cs, mem_ds, mem_rn_w, mem_bank_addr;
    logic [3:0] mem_byte_selects;
    logic       grant_dma, cpu_waitstate, dma_waitstate;

    int n_checks = 0;
    int n_fails  = 0;

    simm_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_cs(cpu_cs), .cpu_ds(cpu_ds), .cpu_rn_w(cpu_rn_w),
        .cpu_bank_addr(cpu_bank_addr), .cpu_byte_selects(cpu_byte_selects),
        .dma_cs(dma_cs), .dma_ds(dma_ds), .dma_rn_w(dma_rn_w),
        .dma_bank_addr(dma_bank_addr), .dma_byte_selects(dma_byte_selects),
        .mem_waitstate(mem_waitstate),
        .mem_cs(mem_cs), .mem_ds(mem_ds), .mem_rn_w(mem_rn_w),
        .mem_bank_addr(mem_bank_addr), .mem_byte_selects(mem_byte_selects),
        .grant_dma(grant_dma), .cpu_waitstate(cpu_waitstate), .dma_waitstate(dma_waitstate)
    );

    always #5 clock = ~clock;

    // {mem_cs, mem_ds, mem_rn_w, mem_bank_addr, mem_byte_selects, grant_dma, cpu_ws, dma_ws}
    function automatic logic [10:0] obs();
        return {mem_cs, mem_ds, mem_rn_w, mem_bank_addr, mem_byte_selects,
                grant_dma, cpu_waitstate, dma_waitstate};
    endfunction

    function automatic logic [1:0] st();
        return dut.state;
    endfunction

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic set_cpu(input logic cs, input logic ds, input logic rnw,
                           input logic bank, input logic [3:0] bs);
        cpu_cs = cs; cpu_ds = ds; cpu_rn_w = rnw; cpu_bank_addr = bank; cpu_byte_selects = bs;
    endtask

    task automatic set_dma(input logic cs, input logic ds, input logic rnw,
                           input logic bank, input logic [3:0] bs);
        dma_cs = cs; dma_ds = ds; dma_rn_w = rnw; dma_bank_addr = bank; dma_byte_selects = bs;
    endtask

    task automatic test_reset();
        logic [10:0] exp;
        reset = 1'b0;
        set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010);
        mem_waitstate = 1'b1;
        step(); step();
        exp = 11'b0_0_1_0_0000_0_1_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL reset_outputs got %b want %b", obs(), exp); end
        n_checks++;
        if (dut.starve_count !== 4'd0) begin n_fails++; $display("FAIL reset_starve got %0d want 0", dut.starve_count); end
        reset = 1'b1;
        step();
        exp = 11'b1_1_0_0_1010_0_1_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL reset_release_grant got %b want %b", obs(), exp); end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(); step();
    endtask

    task automatic test_cpu_read();
        logic [10:0] exp;
        set_cpu(1'b1, 1'b1, 1'b0, 1'b0, 4'b1010);
        mem_waitstate = 1'b1;
        #1;
        exp = 11'b0_0_1_0_0000_0_1_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL cpu_idle_wait got %b want %b", obs(), exp); end
        step();
        exp = 11'b1_1_0_0_1010_0_1_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL cpu_own_pass got %b want %b", obs(), exp); end
        mem_waitstate = 1'b0;
        #1;
        exp = 11'b1_1_0_0_1010_0_0_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL cpu_ws_track got %b want %b", obs(), exp); end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
        n_checks++;
        if (st() !== 2'd3 || mem_cs !== 1'b0) begin
            n_fails++; $display("FAIL cpu_release got state %0d mem_cs %b want state 3 mem_cs 0", st(), mem_cs);
        end
        step();
        n_checks++;
        if (st() !== 2'd0 || mem_cs !== 1'b0) begin
            n_fails++; $display("FAIL cpu_back_idle got state %0d mem_cs %b want state 0 mem_cs 0", st(), mem_cs);
        end
    endtask

    task automatic test_dma_write();
        logic [10:0] exp;
        set_dma(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
        mem_waitstate = 1'b1;
        step();
        exp = 11'b1_1_0_1_1111_1_0_1;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL dma_own_pass got %b want %b", obs(), exp); end
        set_cpu(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
        #1;
        exp = 11'b1_1_0_1_1111_1_1_1;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL dma_cpu_held got %b want %b", obs(), exp); end
        step();
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL dma_keep_own got %b want %b", obs(), exp); end
        mem_waitstate = 1'b0;
        #1;
        exp = 11'b1_1_0_1_1111_1_1_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL dma_ws_track got %b want %b", obs(), exp); end
        set_dma(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
        exp = 11'b0_0_1_0_0000_0_1_0;
        n_checks++;
        if (obs() !== exp || st() !== 2'd3) begin
            n_fails++; $display("FAIL dma_release got %b state %0d want %b state 3", obs(), st(), exp);
        end
        step();
        n_checks++;
        if (obs() !== exp || st() !== 2'd0) begin
            n_fails++; $display("FAIL dma_idle_cpu_wait got %b state %0d want %b state 0", obs(), st(), exp);
        end
        step();
        exp = 11'b1_1_1_0_0011_0_0_0;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL dma_then_cpu got %b want %b", obs(), exp); end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(); step();
    endtask

    task automatic test_starvation();
        logic       exp_grant [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [3:0] exp_sc    [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        set_cpu(1'b1, 1'b1, 1'b1, 1'b0, 4'b0001);
        set_dma(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000);
        mem_waitstate = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            n_checks++;
            if (grant_dma !== exp_grant[k] || dut.starve_count !== exp_sc[k]) begin
                n_fails++;
                $display("FAIL starve_grant_%0d got grant %b count %0d want grant %b count %0d",
                         k, grant_dma, dut.starve_count, exp_grant[k], exp_sc[k]);
            end
            mem_waitstate = 1'b0;
            #1;
            n_checks++;
            if ({cpu_waitstate, dma_waitstate} !== (exp_grant[k] ? 2'b10 : 2'b01)) begin
                n_fails++;
                $display("FAIL starve_ws_%0d got %b want %b", k, {cpu_waitstate, dma_waitstate},
                         exp_grant[k] ? 2'b10 : 2'b01);
            end
            if (exp_grant[k]) dma_cs = 1'b0; else cpu_cs = 1'b0;
            step();
            n_checks++;
            if (st() !== 2'd3 || mem_cs !== 1'b0) begin
                n_fails++; $display("FAIL starve_release_%0d got state %0d mem_cs %b want state 3 mem_cs 0", k, st(), mem_cs);
            end
            if (k < 9) begin
                if (exp_grant[k]) dma_cs = 1'b1; else cpu_cs = 1'b1;
            end
            mem_waitstate = 1'b1;
            step();
        end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        set_dma(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
    endtask

    task automatic test_abort();
        logic [10:0] exp;
        set_cpu(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110);
        set_dma(1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);
        mem_waitstate = 1'b1;
        step();
        exp = 11'b1_1_1_1_0110_0_1_1;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL abort_cpu_own got %b want %b", obs(), exp); end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
        exp = 11'b0_0_1_0_0000_0_0_1;
        n_checks++;
        if (obs() !== exp || st() !== 2'd3) begin
            n_fails++; $display("FAIL abort_release got %b state %0d want %b state 3", obs(), st(), exp);
        end
        step();
        n_checks++;
        if (obs() !== exp || st() !== 2'd0) begin
            n_fails++; $display("FAIL abort_idle got %b state %0d want %b state 0", obs(), st(), exp);
        end
        step();
        exp = 11'b1_1_0_0_1001_1_0_1;
        n_checks++;
        if (obs() !== exp) begin n_fails++; $display("FAIL abort_dma_grant got %b want %b", obs(), exp); end
        set_dma(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step(); step();
    endtask

    task automatic test_async_reset();
        logic [10:0] exp;
        set_cpu(1'b1, 1'b1, 1'b1, 1'b0, 4'b1100);
        set_dma(1'b1, 1'b1, 1'b1, 1'b0, 4'b0011);
        mem_waitstate = 1'b1;
        step();
        n_checks++;
        if (st() !== 2'd1 || dut.starve_count !== 4'd1) begin
            n_fails++; $display("FAIL areset_pre_cpu got state %0d count %0d want state 1 count 1", st(), dut.starve_count);
        end
        #2;
        reset = 1'b0;
        #1;
        exp = 11'b0_0_1_0_0000_0_1_1;
        n_checks++;
        if (obs() !== exp || dut.starve_count !== 4'd0) begin
            n_fails++; $display("FAIL areset_cpu_own got %b count %0d want %b count 0", obs(), dut.starve_count, exp);
        end
        set_cpu(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (grant_dma !== 1'b1 || st() !== 2'd2) begin
            n_fails++; $display("FAIL areset_pre_dma got grant %b state %0d want grant 1 state 2", grant_dma, st());
        end
        #2;
        reset = 1'b0;
        #1;
        exp = 11'b0_0_1_0_0000_0_0_1;
        n_checks++;
        if (obs() !== exp || dut.starve_count !== 4'd0) begin
            n_fails++; $display("FAIL areset_dma_own got %b count %0d want %b count 0", obs(), dut.starve_count, exp);
        end
        set_dma(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000);
        step();
        reset = 1'b1;
        step();
        n_checks++;
        if (st() !== 2'd0 || obs() !== 11'b0_0_1_0_0000_0_0_0) begin
            n_fails++; $display("FAIL areset_after got state %0d out %b want state 0 out %b", st(), obs(), 11'b0_0_1_0_0000_0_0_0);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_starvation();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
